// File: rtl/fifo_method_exerciser.sv
// Caller-side exerciser for an EN_/RDY_ FIFO method interface: enqueues a counting
// sequence starting at SEED and dequeues/checks every element for order and value.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | enqueueing and dequeueing
// DRAIN | all items sent, still dequeueing
// DONE  | run finished, done/pass valid until next start
module fifo_method_exerciser #(
    parameter int unsigned     DW      = 32,
    parameter int unsigned     CW      = 16,
    parameter logic [DW-1:0]   SEED    = DW'(32'h0000_0001),
    parameter int unsigned     TIMEOUT = 1024
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic [CW-1:0] num_items,
    output logic [DW-1:0] enq_data,
    output logic          EN_enqueue,
    input  logic          RDY_enqueue,
    input  logic [DW-1:0] first_data,
    output logic          EN_dequeue,
    input  logic          RDY_dequeue,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] sent_count,
    output logic [CW-1:0] recv_count
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_n, r_sent, r_recv, r_err;
    logic [IW-1:0] r_idle;
    logic [DW-1:0] r_enq_data;
    logic          r_timeout;

    logic          w_start_ok, w_active, w_enq_fire, w_deq_fire;
    logic          w_mismatch, w_idle_cyc, w_to_hit;
    logic [DW-1:0] w_exp;

    assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_active   = (r_state == S_RUN) | (r_state == S_DRAIN);
    assign w_enq_fire = (r_state == S_RUN) & (r_sent < r_n) & RDY_enqueue;
    assign w_deq_fire = w_active & (r_recv < r_n) & RDY_dequeue;
    assign w_exp      = SEED + DW'(r_recv);
    assign w_mismatch = w_deq_fire & (first_data != w_exp);
    assign w_idle_cyc = w_active & ~w_enq_fire & ~w_deq_fire;
    // Fires on the TIMEOUT-th consecutive idle cycle.
    assign w_to_hit   = w_idle_cyc & (r_idle == IW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) w_next = (num_items == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_to_hit)           w_next = S_DONE;
                else if (r_sent == r_n) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_to_hit || r_recv == r_n) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_n        <= '0;
            r_sent     <= '0;
            r_recv     <= '0;
            r_err      <= '0;
            r_idle     <= '0;
            r_enq_data <= SEED;
            r_timeout  <= 1'b0;
        end else if (w_start_ok) begin
            r_n        <= num_items;
            r_sent     <= '0;
            r_recv     <= '0;
            r_err      <= '0;
            r_idle     <= '0;
            r_enq_data <= SEED;
            r_timeout  <= 1'b0;
        end else begin
            if (w_enq_fire) begin
                r_sent     <= r_sent + 1'b1;
                r_enq_data <= r_enq_data + 1'b1;
            end
            if (w_deq_fire) r_recv <= r_recv + 1'b1;
            if (w_mismatch && r_err != '1) r_err <= r_err + 1'b1;
            if (w_enq_fire || w_deq_fire) r_idle <= '0;
            else if (w_idle_cyc)          r_idle <= r_idle + 1'b1;
            if (w_to_hit) r_timeout <= 1'b1;
        end
    end

    assign enq_data   = r_enq_data;
    assign EN_enqueue = w_enq_fire;
    assign EN_dequeue = w_deq_fire;
    assign busy       = w_active;
    assign done       = (r_state == S_DONE);
    assign pass       = done & (r_err == '0) & ~r_timeout & (r_recv == r_n);
    assign timeout    = r_timeout;
    assign err_count  = r_err;
    assign sent_count = r_sent;
    assign recv_count = r_recv;

endmodule

// File: tb/tb_fifo_method_exerciser.sv
// Bench for fifo_method_exerciser: a queue-based FIFO model answers the method
// interface; a table of runs plus random runs are scored against expected outcomes.
module tb_fifo_method_exerciser;

    localparam int          DW      = 32;
    localparam int          CW      = 16;
    localparam logic [31:0] SEED    = 32'h0000_0001;
    localparam int          TIMEOUT = 16;
    localparam int          DEPTH   = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          start;
    logic [CW-1:0] num_items;
    logic [DW-1:0] enq_data;
    logic          EN_enqueue, RDY_enqueue;
    logic [DW-1:0] first_data;
    logic          EN_dequeue, RDY_dequeue;
    logic          busy, done, pass, timeout;
    logic [CW-1:0] err_count, sent_count, recv_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    fifo_method_exerciser #(
        .DW(DW), .CW(CW), .SEED(SEED), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .num_items(num_items),
        .enq_data(enq_data), .EN_enqueue(EN_enqueue), .RDY_enqueue(RDY_enqueue),
        .first_data(first_data), .EN_dequeue(EN_dequeue), .RDY_dequeue(RDY_dequeue),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .sent_count(sent_count), .recv_count(recv_count)
    );

    // mode: 0 all ready, 1 enq 1010 / deq held off 10 cycles, 2 deq never, 3 random
    typedef struct {
        int n;
        int mode;
        int corrupt;
        int poke;
        int exp_err;
        int exp_recv;
        int exp_to;
        int exp_pass;
    } run_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 1'b0);
        chk({tag, "_done"}, 32'(done), 1'b0);
        chk({tag, "_pass"}, 32'(pass), 1'b0);
        chk({tag, "_timeout"}, 32'(timeout), 1'b0);
        chk({tag, "_en_enq"}, 32'(EN_enqueue), 1'b0);
        chk({tag, "_en_deq"}, 32'(EN_dequeue), 1'b0);
        chk({tag, "_enq_data"}, enq_data, SEED);
        chk({tag, "_counts"}, {err_count, sent_count | recv_count}, 32'd0);
    endtask

    task automatic do_run(input run_vec_t v);
        logic [31:0] q[$];
        int  cyc, fires, deqs, sb_err, last_enq;
        bit  fin, ge, gd;
        q = {};
        cyc = 0; fires = 0; deqs = 0; sb_err = 0; last_enq = -1; fin = 0;
        @(negedge CLK);
        start = 1'b1; num_items = CW'(v.n); RDY_enqueue = 1'b0; RDY_dequeue = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        while (!fin && cyc < 400) begin
            case (v.mode)
                0:       begin ge = 1'b1;             gd = 1'b1;        end
                1:       begin ge = (cyc % 2 == 0);   gd = (cyc >= 10); end
                2:       begin ge = 1'b1;             gd = 1'b0;        end
                default: begin ge = ($urandom_range(0, 3) != 0); gd = ($urandom_range(0, 3) != 0); end
            endcase
            if (cyc == v.poke) begin
                start = 1'b1; num_items = CW'(1);
            end
            RDY_enqueue = ge && (q.size() < DEPTH);
            RDY_dequeue = gd && (q.size() > 0);
            first_data  = (q.size() > 0) ? (q[0] ^ ((deqs == v.corrupt) ? 32'd1 : 32'd0))
                                         : 32'hdead_beef;
            #1;
            chk("run_busy", 32'(busy), 1'b1);
            chk("enq_data_seq", enq_data, SEED + 32'(fires));
            if (EN_enqueue) begin
                chk("enq_only_when_rdy", 32'(RDY_enqueue), 1'b1);
                q.push_back(enq_data);
                fires++;
                last_enq = cyc;
            end
            if (EN_dequeue) begin
                chk("deq_only_when_rdy", 32'(RDY_dequeue), 1'b1);
                if (first_data != SEED + 32'(deqs)) sb_err++;
                if (q.size() > 0) void'(q.pop_front());
                deqs++;
            end
            @(negedge CLK);
            start = 1'b0;
            cyc++;
            fin = done;
        end
        if (!fin) chk("done_reached", 32'(done), 1'b1);
        if (v.mode == 0 && v.poke < 0) chk("latency_bound", 32'(cyc <= v.n + 4), 1'b1);
        if (v.exp_to != 0) chk("idle_cycles_to_timeout", 32'(cyc - last_enq - 1), TIMEOUT);
        RDY_enqueue = 1'b1; RDY_dequeue = 1'b1; first_data = '0;
        #1;
        chk("final_done", 32'(done), 1'b1);
        chk("final_busy", 32'(busy), 1'b0);
        chk("final_pass", 32'(pass), 32'(v.exp_pass));
        chk("final_timeout", 32'(timeout), 32'(v.exp_to));
        chk("final_err_count", 32'(err_count), 32'(v.exp_err));
        chk("scoreboard_err", 32'(err_count), 32'(sb_err));
        chk("final_sent_count", 32'(sent_count), 32'(v.n));
        chk("enq_fires", 32'(fires), 32'(v.n));
        chk("final_recv_count", 32'(recv_count), 32'(v.exp_recv));
        chk("deq_fires", 32'(deqs), 32'(v.exp_recv));
        chk("done_no_en", {30'd0, EN_enqueue, EN_dequeue}, 32'd0);
        RDY_enqueue = 1'b0; RDY_dequeue = 1'b0;
    endtask

    run_vec_t vecs[$];
    run_vec_t rv;

    initial begin
        //           n  mode corrupt poke err recv to pass
        vecs.push_back('{4, 0, -1, -1, 0, 4, 0, 1});
        vecs.push_back('{8, 1, -1, -1, 0, 8, 0, 1});
        vecs.push_back('{5, 0,  2, -1, 1, 5, 0, 0});
        vecs.push_back('{2, 2, -1, -1, 0, 0, 1, 0});
        vecs.push_back('{1, 0, -1, -1, 0, 1, 0, 1});
        vecs.push_back('{6, 0, -1,  2, 0, 6, 0, 1});
        vecs.push_back('{3, 0,  0, -1, 1, 3, 0, 0});

        RST_N = 1'b0; start = 1'b0; num_items = '0;
        RDY_enqueue = 1'b1; RDY_dequeue = 1'b1; first_data = '0;
        #12;
        chk_idle_outputs("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        RDY_enqueue = 1'b0; RDY_dequeue = 1'b0;

        foreach (vecs[i]) do_run(vecs[i]);

        // N=0 completes the cycle after start without any method enable
        @(negedge CLK);
        start = 1'b1; num_items = '0; RDY_enqueue = 1'b1; RDY_dequeue = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        chk("n0_done", 32'(done), 1'b1);
        chk("n0_pass", 32'(pass), 1'b1);
        chk("n0_en_enq", 32'(EN_enqueue), 1'b0);
        chk("n0_busy", 32'(busy), 1'b0);
        RDY_enqueue = 1'b0;

        // random runs against the reference expectations
        for (int r = 0; r < 6; r++) begin
            rv.n = int'($urandom_range(1, 20));
            rv.mode = 3;
            rv.corrupt = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, rv.n - 1)) : -1;
            rv.poke = -1;
            rv.exp_err = (rv.corrupt >= 0) ? 1 : 0;
            rv.exp_recv = rv.n;
            rv.exp_to = 0;
            rv.exp_pass = (rv.exp_err == 0) ? 1 : 0;
            do_run(rv);
        end

        // asynchronous reset in the middle of a RUN cycle
        @(negedge CLK);
        start = 1'b1; num_items = CW'(10); RDY_enqueue = 1'b1; RDY_dequeue = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pre_reset_busy", 32'(busy), 1'b1);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk_idle_outputs("midrun_reset");
        @(negedge CLK);
        RST_N = 1'b1;
        RDY_enqueue = 1'b0;
        do_run('{3, 0, -1, -1, 0, 3, 0, 1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

endmodule
